divider_sched: RTL



---
 rtl/divsched_pkg.sv | 7 +
 rtl/divider_sched_if.sv | 25 ++
 rtl/divsched_pending.sv | 38 +++
 rtl/divider_sched.sv | 92 +++++++++
 4 files changed

// File: rtl/divsched_pkg.sv
// divsched_pkg: shared types and defaults for the divide-counter scheduler.
package divsched_pkg;
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_MIN_DIV = 2;
   localparam int STOP_DIV    = 0;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
endpackage

// File: rtl/divider_sched_if.sv
// divider_sched_if: config handshake and divider-control bundle.
// clk_out exists only when DIVSCHED_HALF_DUTY_EN is defined.
interface divider_sched_if #(parameter int WIDTH = divsched_pkg::DEF_WIDTH);
   logic             en;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_div;
   logic             load_n;
   logic [WIDTH-1:0] load_val;
   logic             tick;
   logic             busy;
   logic [WIDTH-1:0] cur_div;
`ifdef DIVSCHED_HALF_DUTY_EN
   logic             clk_out;
   modport slave (input en, cfg_valid, cfg_div,
                  output cfg_ready, load_n, load_val, tick, busy, cur_div, clk_out);
   modport master (output en, cfg_valid, cfg_div,
                   input cfg_ready, load_n, load_val, tick, busy, cur_div, clk_out);
`else
   modport slave (input en, cfg_valid, cfg_div,
                  output cfg_ready, load_n, load_val, tick, busy, cur_div);
   modport master (output en, cfg_valid, cfg_div,
                   input cfg_ready, load_n, load_val, tick, busy, cur_div);
`endif
endinterface

// File: rtl/divsched_pending.sv
// divsched_pending: single-entry ratio holding slot with clamp and ready.
module divsched_pending
   import divsched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MIN_DIV = DEF_MIN_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] clamp_o,
   output logic [WIDTH-1:0] pend_o,
   output logic             full_o,
   output logic             ready_o
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   // a stop request (0) passes through unclamped
   assign clamp_o = (div_i != WIDTH'(STOP_DIV) && div_i < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_i;
   always_comb begin
      full_d = wr_i ? 1'b1 : clr_i ? 1'b0 : full_q;
      pend_d = wr_i ? clamp_o : clr_i ? '0 : pend_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         pend_q <= '0;
      end else begin
         full_q <= full_d;
         pend_q <= pend_d;
      end
   end
   assign pend_o  = pend_q;
   assign full_o  = full_q;
   assign ready_o = !full_q;
endmodule

// File: rtl/divider_sched.sv
// divider_sched: sequences the programmable divide counter; ratio swaps at period edges.
// tick is registered and shows in the cycle after terminal count. Option: DIVSCHED_HALF_DUTY_EN.
module divider_sched
   import divsched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MIN_DIV = DEF_MIN_DIV
) (
   input logic            clk,
   input logic            rst_n,
   divider_sched_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] cur_div_q, cur_div_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] load_val_q;
   logic             load_n_q, tick_q, busy_q;
   logic [WIDTH-1:0] clamp, pend_div;
   logic             pend_full, pend_ready, pend_wr, pend_clr, term;
   assign pend_wr = bus.cfg_valid && pend_ready && state_q != IDLE;
   assign term    = state_q == RUN && bus.en && count_q == '0;
   divsched_pending #(.WIDTH(WIDTH), .MIN_DIV(MIN_DIV)) u_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (pend_wr),
      .clr_i   (pend_clr),
      .div_i   (bus.cfg_div),
      .clamp_o (clamp),
      .pend_o  (pend_div),
      .full_o  (pend_full),
      .ready_o (pend_ready)
   );
   always_comb begin
      state_d   = state_q;
      cur_div_d = cur_div_q;
      count_d   = count_q;
      pend_clr  = 1'b0;
      case (state_q)
         IDLE: if (bus.cfg_valid && clamp != WIDTH'(STOP_DIV)) begin
            cur_div_d = clamp;
            state_d   = LOAD;
         end
         LOAD: begin
            count_d = cur_div_q - ONE;
            state_d = RUN;
         end
         RUN: if (term) begin
            if (!pend_full) count_d = cur_div_q - ONE;
            else begin
               pend_clr  = 1'b1;
               cur_div_d = pend_div;
               state_d   = (pend_div == WIDTH'(STOP_DIV)) ? IDLE : LOAD;
            end
         end else if (bus.en) count_d = count_q - ONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_div_q  <= '0;
         count_q    <= '0;
         load_n_q   <= 1'b1;
         load_val_q <= '0;
         tick_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_div_q  <= cur_div_d;
         count_q    <= count_d;
         load_n_q   <= state_d != LOAD;
         load_val_q <= (state_d == LOAD) ? cur_div_d - ONE : load_val_q;
         tick_q     <= term;
         busy_q     <= state_d != IDLE;
      end
   end
`ifdef DIVSCHED_HALF_DUTY_EN
   logic clk_out_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_out_q <= 1'b0;
      else clk_out_q <= state_d == RUN && count_d >= (cur_div_d >> 1);
   end
   assign bus.clk_out = clk_out_q;
`endif
   assign bus.cfg_ready = state_q == IDLE || pend_ready;
   assign bus.load_n    = load_n_q;
   assign bus.load_val  = load_val_q;
   assign bus.tick      = tick_q;
   assign bus.busy      = busy_q;
   assign bus.cur_div   = cur_div_q;
endmodule
